// File: rtl/encoder_input_filter.sv
// encoder_input_filter
//   Conditions raw quadrature encoder pins before they reach the decoder.
//   The pins are synchronised into the clk domain, then sampled on a
//   programmable prescaler tick. A new level is accepted only after
//   FILTER_LEN consecutive differing samples. The block also reports
//   Gray-code violations and counts rejected glitches.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   enable       1 = filtering active, 0 = sampling frozen and outputs held
//   enc_a_in     raw channel A pin (asynchronous)
//   enc_b_in     raw channel B pin (asynchronous)
//   sample_div   sample tick period minus 1 (0 = sample every cycle)
//   err_clear    clears err_illegal (a simultaneous set takes priority)
//   enc_a/enc_b  filtered levels for the decoder
//   edge_pulse   one-cycle strobe after any enc_a/enc_b change
//   err_illegal  sticky flag: A and B changed on the same edge
//   glitch_count saturating count of ticks that rejected a glitch
module encoder_input_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 enc_a_in,
  input  logic                 enc_b_in,
  input  logic [DIV_WIDTH-1:0] sample_div,
  input  logic                 err_clear,
  output logic                 enc_a,
  output logic                 enc_b,
  output logic                 edge_pulse,
  output logic                 err_illegal,
  output logic [CNT_WIDTH-1:0] glitch_count
);

  // A one-sample filter still needs a 1-bit counter that never leaves 0.
  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] FLAST = FW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic                   sample_a;
  logic                   sample_b;
  logic [DIV_WIDTH-1:0]   div_cnt;
  logic                   tick;
  logic [FW-1:0]          cnt_a;
  logic [FW-1:0]          cnt_b;
  logic [FW-1:0]          cnt_a_nxt;
  logic [FW-1:0]          cnt_b_nxt;
  logic                   a_nxt;
  logic                   b_nxt;
  logic                   glitch_a;
  logic                   glitch_b;
  logic                   chg_a;
  logic                   chg_b;

  assign sample_a = sync_a[SYNC_STAGES-1];
  assign sample_b = sync_b[SYNC_STAGES-1];

  // >= rather than == so that lowering sample_div mid-count cannot strand
  // the counter above the new terminal value.
  assign tick = enable && (div_cnt >= sample_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a  <= '0;
      sync_b  <= '0;
      div_cnt <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], enc_a_in};
      sync_b <= {sync_b[SYNC_STAGES-2:0], enc_b_in};
      if (!enable || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Channel A filter: a run of differing samples that ends before
  // reaching FILTER_LEN is a glitch.
  always_comb begin
    a_nxt     = enc_a;
    cnt_a_nxt = cnt_a;
    glitch_a  = 1'b0;
    if (tick) begin
      if (sample_a == enc_a) begin
        cnt_a_nxt = '0;
        glitch_a  = (cnt_a != '0);
      end else if (cnt_a == FLAST) begin
        a_nxt     = sample_a;
        cnt_a_nxt = '0;
      end else begin
        cnt_a_nxt = cnt_a + 1'b1;
      end
    end
  end

  always_comb begin
    b_nxt     = enc_b;
    cnt_b_nxt = cnt_b;
    glitch_b  = 1'b0;
    if (tick) begin
      if (sample_b == enc_b) begin
        cnt_b_nxt = '0;
        glitch_b  = (cnt_b != '0);
      end else if (cnt_b == FLAST) begin
        b_nxt     = sample_b;
        cnt_b_nxt = '0;
      end else begin
        cnt_b_nxt = cnt_b + 1'b1;
      end
    end
  end

  assign chg_a = a_nxt ^ enc_a;
  assign chg_b = b_nxt ^ enc_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_a        <= '0;
      cnt_b        <= '0;
      enc_a        <= 1'b0;
      enc_b        <= 1'b0;
      edge_pulse   <= 1'b0;
      err_illegal  <= 1'b0;
      glitch_count <= '0;
    end else begin
      cnt_a      <= cnt_a_nxt;
      cnt_b      <= cnt_b_nxt;
      enc_a      <= a_nxt;
      enc_b      <= b_nxt;
      edge_pulse <= chg_a | chg_b;
      if (chg_a && chg_b) begin
        err_illegal <= 1'b1;
      end else if (err_clear) begin
        err_illegal <= 1'b0;
      end
      // A and B glitching on the same tick counts once.
      if ((glitch_a || glitch_b) && (glitch_count != '1)) begin
        glitch_count <= glitch_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_encoder_input_filter.sv
module tb_encoder_input_filter;
  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 4;
  localparam int DIV_WIDTH   = 16;
  localparam int CNT_WIDTH   = 4;
  localparam int GC_MAX      = (1 << CNT_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 enc_a_in;
  logic                 enc_b_in;
  logic [DIV_WIDTH-1:0] sample_div;
  logic                 err_clear;
  logic                 enc_a;
  logic                 enc_b;
  logic                 edge_pulse;
  logic                 err_illegal;
  logic [CNT_WIDTH-1:0] glitch_count;

  int checks = 0;
  int errors = 0;

  encoder_input_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN),
    .DIV_WIDTH  (DIV_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .enc_a_in    (enc_a_in),
    .enc_b_in    (enc_b_in),
    .sample_div  (sample_div),
    .err_clear   (err_clear),
    .enc_a       (enc_a),
    .enc_b       (enc_b),
    .edge_pulse  (edge_pulse),
    .err_illegal (err_illegal),
    .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Pins travel through a SYNC_STAGES-deep queue; each channel remembers how
  // many consecutive tick samples have disagreed with its output so far.
  bit m_sq_a[$];
  bit m_sq_b[$];
  int m_pend_a, m_pend_b, m_pcnt, m_gc;
  bit m_a, m_b, m_ep, m_err;

  function automatic void filt(input bit s, input bit o, input int pend,
                               output bit no, output int npend, output bit g);
    no = o;
    npend = pend;
    g = 1'b0;
    if (s == o) begin
      g = (pend > 0);
      npend = 0;
    end else if (pend + 1 == FILTER_LEN) begin
      no = s;
      npend = 0;
    end else begin
      npend = pend + 1;
    end
  endfunction

  always @(posedge clk or posedge reset) begin : model
    bit sa, sb, na, nb, ga, gb, tk;
    int pa, pb;
    if (reset) begin
      m_sq_a = {};
      m_sq_b = {};
      for (int i = 0; i < SYNC_STAGES; i++) begin
        m_sq_a.push_back(1'b0);
        m_sq_b.push_back(1'b0);
      end
      m_pend_a = 0; m_pend_b = 0; m_pcnt = 0; m_gc = 0;
      m_a = 0; m_b = 0; m_ep = 0; m_err = 0;
    end else begin
      sa = m_sq_a[0];
      sb = m_sq_b[0];
      void'(m_sq_a.pop_front());
      void'(m_sq_b.pop_front());
      m_sq_a.push_back(enc_a_in);
      m_sq_b.push_back(enc_b_in);
      tk = enable && (m_pcnt >= int'(sample_div));
      m_pcnt = (!enable || tk) ? 0 : m_pcnt + 1;
      na = m_a; nb = m_b; ga = 0; gb = 0; pa = m_pend_a; pb = m_pend_b;
      if (tk) begin
        filt(sa, m_a, m_pend_a, na, pa, ga);
        filt(sb, m_b, m_pend_b, nb, pb, gb);
      end
      m_ep = (na != m_a) || (nb != m_b);
      if ((na != m_a) && (nb != m_b)) m_err = 1;
      else if (err_clear) m_err = 0;
      if ((ga || gb) && m_gc < GC_MAX) m_gc++;
      m_a = na; m_b = nb; m_pend_a = pa; m_pend_b = pb;
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b1;
    enc_a_in = 1'b0;
    enc_b_in = 1'b0;
    sample_div = '0;
    err_clear = 1'b0;
    step(2);
    check("rst_enc_a", enc_a, 0);
    check("rst_enc_b", enc_b, 0);
    check("rst_edge", edge_pulse, 0);
    check("rst_err", err_illegal, 0);
    check("rst_gc", glitch_count, 0);
    reset = 1'b0;
  endtask

  typedef struct {
    bit a;
    bit b;
    int cycles;
    bit ea;
    bit eb;
    bit ep;
    bit err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    enc_a_in = 1'b0;
    enc_b_in = 1'b0;
    sample_div = '0;
    err_clear = 1'b0;

    vecs[0] = '{a:1, b:0, cycles:5, ea:0, eb:0, ep:0, err:0};
    vecs[1] = '{a:1, b:0, cycles:1, ea:1, eb:0, ep:1, err:0};
    vecs[2] = '{a:1, b:1, cycles:6, ea:1, eb:1, ep:1, err:0};
    vecs[3] = '{a:0, b:0, cycles:5, ea:1, eb:1, ep:0, err:0};
    vecs[4] = '{a:0, b:0, cycles:1, ea:0, eb:0, ep:1, err:1};
    vecs[5] = '{a:0, b:0, cycles:3, ea:0, eb:0, ep:0, err:1};

    // Latency of a clean step on A
    do_reset();
    enc_a_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check("lat_enc_a", enc_a, (k >= 6) ? 1 : 0);
      check("lat_edge", edge_pulse, (k == 6) ? 1 : 0);
    end
    check("lat_gc", glitch_count, 0);
    check("lat_err", err_illegal, 0);

    // 3-cycle pulse is rejected as one glitch
    do_reset();
    enc_a_in = 1'b1;
    step(3);
    enc_a_in = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      check("gl_enc_a", enc_a, 0);
      check("gl_edge", edge_pulse, 0);
    end
    check("gl_gc", glitch_count, 1);

    // Prescaled step on B: accepted on the 4th tick (edge 40)
    do_reset();
    sample_div = 16'd9;
    enc_b_in = 1'b1;
    for (int k = 1; k <= 42; k++) begin
      step(1);
      if (k == 39) check("div_enc_b_early", enc_b, 0);
      if (k == 40) check("div_enc_b", enc_b, 1);
    end

    // Prescaled 25-cycle pulse rejected
    do_reset();
    sample_div = 16'd9;
    enc_b_in = 1'b1;
    step(25);
    enc_b_in = 1'b0;
    step(60);
    check("div_gl_enc_b", enc_b, 0);
    check("div_gl_gc", glitch_count, 1);

    // Table-driven sequence with sample_div = 0
    do_reset();
    foreach (vecs[i]) begin
      enc_a_in = vecs[i].a;
      enc_b_in = vecs[i].b;
      step(vecs[i].cycles);
      check("tbl_enc_a", enc_a, vecs[i].ea);
      check("tbl_enc_b", enc_b, vecs[i].eb);
      check("tbl_edge", edge_pulse, vecs[i].ep);
      check("tbl_err", err_illegal, vecs[i].err);
    end

    // Simultaneous toggle with err_clear on the same edge: set wins
    enc_a_in = 1'b1;
    enc_b_in = 1'b1;
    step(5);
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    check("sc_enc_a", enc_a, 1);
    check("sc_enc_b", enc_b, 1);
    check("sc_edge", edge_pulse, 1);
    check("sc_err_set_wins", err_illegal, 1);
    step(2);
    check("sc_err_hold", err_illegal, 1);
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    check("sc_err_cleared", err_illegal, 0);

    // Glitch counter saturation
    do_reset();
    for (int k = 0; k < 20; k++) begin
      enc_a_in = 1'b1;
      step(1);
      enc_a_in = 1'b0;
      step(1);
    end
    step(6);
    check("sat_gc", glitch_count, GC_MAX);
    check("sat_enc_a", enc_a, 0);

    // Reset while the filters are mid-count
    do_reset();
    enc_a_in = 1'b1;
    enc_b_in = 1'b1;
    step(8);
    check("mr_pre_enc_a", enc_a, 1);
    check("mr_pre_err", err_illegal, 1);
    enc_a_in = 1'b0;
    enc_b_in = 1'b0;
    step(4);
    #2;
    reset = 1'b1;
    #1;
    check("mr_enc_a", enc_a, 0);
    check("mr_enc_b", enc_b, 0);
    check("mr_edge", edge_pulse, 0);
    check("mr_err", err_illegal, 0);
    check("mr_gc", glitch_count, 0);
    enc_a_in = 1'b1;
    step(1);
    reset = 1'b0;
    step(1);
    enc_b_in = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      step(1);
      check("mr_reacq_a", enc_a, (k >= 6) ? 1 : 0);
      check("mr_reacq_b", enc_b, (k >= 7) ? 1 : 0);
      check("mr_reacq_err", err_illegal, 0);
    end

    // Randomised run against the reference model
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step(1);
      check("rnd_enc_a", enc_a, m_a);
      check("rnd_enc_b", enc_b, m_b);
      check("rnd_edge", edge_pulse, m_ep);
      check("rnd_err", err_illegal, m_err);
      check("rnd_gc", glitch_count, m_gc);
      if ($urandom_range(0, 29) == 0) begin
        enc_a_in = ~enc_a_in;
        enc_b_in = ~enc_b_in;
      end else begin
        if ($urandom_range(0, 5) == 0) enc_a_in = ~enc_a_in;
        if ($urandom_range(0, 5) == 0) enc_b_in = ~enc_b_in;
      end
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 299) == 0) sample_div = 16'($urandom_range(0, 3));
      err_clear = ($urandom_range(0, 39) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_input_filter.md
Name: encoder_input_filter

Overview:
Conditioning stage placed directly upstream of the quadrature decoder. It synchronises the raw A/B encoder pins into the clk domain, removes glitches shorter than a programmable number of samples, and drives clean A/B levels to the decoder. It also flags Gray-code violations (A and B changing together) and counts rejected glitches for diagnostics.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per channel (>=2)
FILTER_LEN, 4, consecutive agreeing samples required to accept a new level (>=1)
DIV_WIDTH, 16, width of sample_div
CNT_WIDTH, 16, width of glitch_count

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = filtering active; 0 = sampling frozen, outputs hold
enc_a_in  input  1  raw channel A pin (asynchronous)
enc_b_in  input  1  raw channel B pin (asynchronous)
sample_div  input  DIV_WIDTH  sample tick period minus 1 (0 = sample every cycle)
err_clear  input  1  clears err_illegal
enc_a  output  1  filtered channel A, feeds the decoder
enc_b  output  1  filtered channel B, feeds the decoder
edge_pulse  output  1  one-cycle strobe on any enc_a/enc_b change
err_illegal  output  1  sticky: A and B changed on the same edge
glitch_count  output  CNT_WIDTH  saturating count of rejected glitches

Behaviour:
- Reset (asynchronous assert, released on clk): all synchroniser flops, prescaler, filter counters, enc_a, enc_b, edge_pulse, err_illegal and glitch_count go to 0.
- Synchroniser: SYNC_STAGES flops per channel, clocked every cycle regardless of enable. The filter uses only the last stage.
- Prescaler: counter runs 0..sample_div. A tick fires in the cycle where count >= sample_div, and count returns to 0. The >= compare covers sample_div being lowered mid-count. sample_div = 0 means a tick every cycle. While enable = 0, count is held at 0 and no ticks fire.
- Filter (per channel, evaluated only on a tick):
  - If sample == output: counter is cleared. If counter was nonzero, this is a glitch.
  - If sample != output and counter == FILTER_LEN-1: output takes the sample value and counter is cleared.
  - Otherwise counter increments.
  - FILTER_LEN = 1: output follows the sample on the first differing tick.
- Latency: with sample_div = 0, an input held stable appears on the output SYNC_STAGES + FILTER_LEN clock edges after it is first captured (6 for the defaults).
- glitch_count: increments by 1 on any tick where at least one channel detects a glitch. A and B glitching on the same tick still adds only 1. Saturates at all-ones and does not wrap.
- edge_pulse: registered, high for exactly the one cycle following any edge where enc_a or enc_b changed.
- err_illegal: set on the edge where enc_a and enc_b both change. It stays set until err_clear is sampled high. Set and clear in the same cycle leaves it set (set wins). On that edge edge_pulse still fires and both outputs still update.
- enable fall mid-filter: counters and outputs hold their values. Filtering resumes from the held state when enable returns to 1.
- Reset mid-operation: immediate return to the reset state. After release, enc_a and enc_b re-acquire the pin levels through the normal filter path, so no edge_pulse or error is produced by reset itself.

Test Plan:
- Defaults, sample_div = 0, enc_a_in 0->1 and held -> enc_a rises exactly 6 edges later; edge_pulse high 1 cycle; glitch_count = 0; err_illegal = 0.
- enc_a_in pulse 3 cycles wide, sample_div = 0, FILTER_LEN = 4 -> enc_a stays 0; glitch_count = 1; no edge_pulse.
- sample_div = 9, enc_b_in step held -> enc_b changes after 4 ticks (about 40 cycles plus sync), not before; a 25-cycle pulse is rejected.
- Both pins toggle together and are held -> enc_a and enc_b change on the same edge; err_illegal = 1. Pulse err_clear together with a new simultaneous toggle -> err_illegal stays 1. err_clear alone -> 0.
- Repeated 1-cycle glitches with CNT_WIDTH forced to 4 -> glitch_count saturates at 15.
- Assert reset while the filter counter is at 2 -> all outputs 0 immediately; after release, pins held high -> enc_a = enc_b = 1 after 6 edges; err_illegal stays 0.
